// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator: turns one core op at a time into a byte-masked
// 32-bit memory request and returns one extended (or error) result per op.
module lsu_mem_initiator #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_data,
  output logic [3:0]        m_mask,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic op_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic bad_v;
    case (f3)
      3'b000:  bad_v = 1'b0;
      3'b001:  bad_v = lo[0];
      3'b010:  bad_v = (lo != 2'b00);
      3'b100:  bad_v = we;
      3'b101:  bad_v = we | lo[0];
      default: bad_v = 1'b1;
    endcase
    return bad_v;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d_v;
    case (f3[1:0])
      2'b00:   d_v = {4{wd[7:0]}};
      2'b01:   d_v = {2{wd[15:0]}};
      default: d_v = wd;
    endcase
    return d_v;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] m_v;
    case (f3[1:0])
      2'b00:   m_v = 4'b0001 << lo;
      2'b01:   m_v = lo[1] ? 4'b1100 : 4'b0011;
      default: m_v = 4'b1111;
    endcase
    return m_v;
  endfunction

  // Lane select by address offset, then sign- or zero-extend per funct3.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [31:0] sh_v;
    logic [15:0] h_v;
    logic [31:0] r_v;
    sh_v = d >> {lo, 3'b000};
    h_v  = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r_v = {{24{sh_v[7]}}, sh_v[7:0]};
      3'b001:  r_v = {{16{h_v[15]}}, h_v};
      3'b100:  r_v = {24'd0, sh_v[7:0]};
      3'b101:  r_v = {16'd0, h_v};
      default: r_v = d;
    endcase
    return r_v;
  endfunction

  state_t            state_r, state_nx_s;
  logic              req_ready_r, req_ready_nx_s;
  logic              rsp_valid_r, rsp_valid_nx_s;
  logic [31:0]       rsp_data_r, rsp_data_nx_s;
  logic              rsp_err_r, rsp_err_nx_s;
  logic              m_valid_r, m_valid_nx_s;
  logic              m_we_r, m_we_nx_s;
  logic [ADDR_W-1:0] m_addr_r, m_addr_nx_s;
  logic [31:0]       m_data_r, m_data_nx_s;
  logic [3:0]        m_mask_r, m_mask_nx_s;
  logic              s_ready_r, s_ready_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic [2:0]        op_f3_r, op_f3_nx_s;
  logic [1:0]        op_lo_r, op_lo_nx_s;

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP sequencer.
  always_comb begin
    state_nx_s     = state_r;
    req_ready_nx_s = 1'b0;
    rsp_valid_nx_s = 1'b0;
    rsp_data_nx_s  = 32'd0;
    rsp_err_nx_s   = 1'b0;
    m_valid_nx_s   = 1'b0;
    m_we_nx_s      = 1'b0;
    m_addr_nx_s    = '0;
    m_data_nx_s    = 32'd0;
    m_mask_nx_s    = 4'd0;
    s_ready_nx_s   = 1'b0;
    cnt_nx_s       = cnt_r;
    op_f3_nx_s     = op_f3_r;
    op_lo_nx_s     = op_lo_r;
    case (state_r)
      ST_IDLE: begin
        req_ready_nx_s = 1'b1;
        if (req_valid && req_ready_r) begin
          req_ready_nx_s = 1'b0;
          op_f3_nx_s     = req_funct3;
          op_lo_nx_s     = req_addr[1:0];
          if (op_bad(req_we, req_funct3, req_addr[1:0])) begin
            state_nx_s     = ST_RESP;
            rsp_valid_nx_s = 1'b1;
            rsp_err_nx_s   = 1'b1;
          end else begin
            state_nx_s   = ST_ISSUE;
            m_valid_nx_s = 1'b1;
            m_we_nx_s    = req_we;
            m_addr_nx_s  = {req_addr[ADDR_W-1:2], 2'b00};
            m_data_nx_s  = req_we ? store_data(req_funct3, req_wdata) : 32'd0;
            m_mask_nx_s  = req_we ? store_mask(req_funct3, req_addr[1:0]) : 4'b1111;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_ready && m_valid_r) begin
          if (m_we_r) begin
            state_nx_s     = ST_RESP;
            rsp_valid_nx_s = 1'b1;
          end else begin
            state_nx_s   = ST_WAIT;
            s_ready_nx_s = 1'b1;
            cnt_nx_s     = '0;
          end
        end else begin
          m_valid_nx_s = 1'b1;
          m_we_nx_s    = m_we_r;
          m_addr_nx_s  = m_addr_r;
          m_data_nx_s  = m_data_r;
          m_mask_nx_s  = m_mask_r;
        end
      end
      ST_WAIT: begin
        if (s_valid) begin
          state_nx_s     = ST_RESP;
          rsp_valid_nx_s = 1'b1;
          rsp_data_nx_s  = load_ext(op_f3_r, op_lo_r, s_data);
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
          state_nx_s     = ST_RESP;
          rsp_valid_nx_s = 1'b1;
          rsp_err_nx_s   = 1'b1;
        end else begin
          s_ready_nx_s = 1'b1;
          cnt_nx_s     = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx_s     = ST_IDLE;
          req_ready_nx_s = 1'b1;
        end else begin
          rsp_valid_nx_s = 1'b1;
          rsp_data_nx_s  = rsp_data_r;
          rsp_err_nx_s   = rsp_err_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, registered outputs, timeout counter and captured op.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      rsp_err_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      m_we_r      <= 1'b0;
      m_addr_r    <= '0;
      m_data_r    <= 32'd0;
      m_mask_r    <= 4'd0;
      s_ready_r   <= 1'b0;
      cnt_r       <= '0;
      op_f3_r     <= 3'd0;
      op_lo_r     <= 2'd0;
    end else begin
      state_r     <= state_nx_s;
      req_ready_r <= req_ready_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
      rsp_data_r  <= rsp_data_nx_s;
      rsp_err_r   <= rsp_err_nx_s;
      m_valid_r   <= m_valid_nx_s;
      m_we_r      <= m_we_nx_s;
      m_addr_r    <= m_addr_nx_s;
      m_data_r    <= m_data_nx_s;
      m_mask_r    <= m_mask_nx_s;
      s_ready_r   <= s_ready_nx_s;
      cnt_r       <= cnt_nx_s;
      op_f3_r     <= op_f3_nx_s;
      op_lo_r     <= op_lo_nx_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign m_valid   = m_valid_r;
  assign m_we      = m_we_r;
  assign m_addr    = m_addr_r;
  assign m_data    = m_data_r;
  assign m_mask    = m_mask_r;
  assign s_ready   = s_ready_r;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed plus randomized bench for lsu_mem_initiator against a byte-array
// memory model and RV32I load/store rules computed in the bench.
module tb_lsu_mem_initiator;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rstf;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        m_valid, m_ready, m_we;
  logic [14:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  logic        s_valid, s_ready;
  logic [31:0] s_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_b [0:511];

  lsu_mem_initiator #(.ADDR_W(15), .TIMEOUT(TO)) dut (
    .clk(clk), .rstf(rstf),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
    .m_data(m_data), .m_mask(m_mask),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic bit ref_bad(input bit we, input logic [2:0] f3, input int addr);
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (addr % ref_size(f3)) != 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp"}, {rsp_data[31:1], rsp_data[0] | rsp_valid | rsp_err}, 32'd0);
    chk({tag, "_m_ctl"}, {26'd0, m_valid, m_we, m_mask}, 32'd0);
    chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_m_data"}, m_data, 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic wait_req_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic accept(input bit we, input logic [2:0] f3, input int addr, input logic [31:0] wd);
    wait_req_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = 15'(addr);
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
    req_wdata  = $urandom;
  endtask

  task automatic run_op(input bit we, input logic [2:0] f3, input int addr,
                        input logic [31:0] wd, input int mdly, input int rdly);
    int size, base;
    bit bad, exp_err;
    logic [31:0] exp_d, exp_md, v;
    logic [3:0] exp_mask;
    size = ref_size(f3);
    base = addr - (addr % 4);
    bad  = ref_bad(we, f3, addr);
    exp_d = 32'd0;
    exp_err = bad;
    accept(we, f3, addr, wd);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (bad) begin
      chk("err_no_mvalid", 32'(m_valid), 32'd0);
      chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
    end else begin
      exp_mask = 4'd0;
      exp_md   = 32'd0;
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (base + i >= addr && base + i < addr + size) exp_mask[i] = 1'b1;
          exp_md[8*i +: 8] = wd[8*(i % size) +: 8];
        end
      end else begin
        exp_mask = 4'b1111;
      end
      for (int k = 0; k <= mdly; k++) begin
        chk("m_valid", 32'(m_valid), 32'd1);
        chk("m_we", 32'(m_we), 32'(we));
        chk("m_addr", 32'(m_addr), 32'(base));
        chk("m_data", m_data, exp_md);
        chk("m_mask", 32'(m_mask), 32'(exp_mask));
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        if (k < mdly) tick();
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("m_valid_drop", 32'(m_valid), 32'd0);
      if (we) begin
        for (int i = 0; i < size; i++) mem_b[addr + i] = wd[8*i +: 8];
        chk("st_rsp_valid", 32'(rsp_valid), 32'd1);
      end else begin
        chk("ld_s_ready", 32'(s_ready), 32'd1);
        chk("ld_rsp_early", 32'(rsp_valid), 32'd0);
        s_valid = 1'b1;
        s_data  = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
        tick();
        s_valid = 1'b0;
        s_data  = $urandom;
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem_b[addr + i];
        if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        exp_d = v;
        chk("ld_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ld_s_ready_off", 32'(s_ready), 32'd0);
      end
    end
    for (int k = 0; k <= rdly; k++) begin
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_hold", 32'(rsp_valid), 32'd1);
      chk("req_ready_resp", 32'(req_ready), 32'd0);
      if (k < rdly) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstf = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 15'd0; req_wdata = 32'd0; rsp_ready = 1'b0; m_ready = 1'b0;
    s_valid = 1'b0; s_data = 32'd0;
    for (int i = 0; i < 512; i++) mem_b[i] = 8'd0;
    repeat (3) tick();
    chk_all_zero("reset");
    rstf = 1'b1;
    #1;
    chk("req_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Spec scenarios 1-3
    run_op(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 0);
    run_op(1'b1, 3'b000, 32'h13, 32'h000000A5, 1, 0);
    run_op(1'b1, 3'b010, 32'h10, 32'h80FF1234, 0, 0);
    run_op(1'b0, 3'b000, 32'h13, 32'd0, 0, 0);
    run_op(1'b0, 3'b100, 32'h13, 32'd0, 0, 0);
    run_op(1'b0, 3'b001, 32'h12, 32'd0, 0, 0);
    run_op(1'b0, 3'b101, 32'h12, 32'd0, 0, 0);
    run_op(1'b0, 3'b010, 32'h10, 32'd0, 0, 0);
    run_op(1'b1, 3'b001, 32'h22, 32'h1234CAFE, 0, 1);
    // Errors: misaligned, illegal funct3, unsigned store
    run_op(1'b0, 3'b010, 32'h06, 32'd0, 0, 0);
    run_op(1'b0, 3'b011, 32'h10, 32'd0, 0, 0);
    run_op(1'b1, 3'b100, 32'h10, 32'd0, 0, 0);
    run_op(1'b0, 3'b001, 32'h11, 32'd0, 0, 2);
    // m_ready held low, rsp_ready held low
    run_op(1'b0, 3'b010, 32'h10, 32'd0, 3, 0);
    run_op(1'b0, 3'b000, 32'h13, 32'd0, 0, 4);

    // Timeout with no read response, then a late response is ignored
    accept(1'b0, 3'b010, 32'h20, 32'd0);
    chk("to_m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("to_s_ready", 32'(s_ready), 32'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles_in_range", 32'(n >= TO && n <= TO + 1), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    chk("to_s_ready_off", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data  = 32'h5A5A_1234;
    tick();
    s_valid = 1'b0;
    chk("late_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("late_rsp_data", rsp_data, 32'd0);
    chk("late_rsp_err", 32'(rsp_err), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("idle_svalid_no_rsp", 32'(rsp_valid), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Randomized ops against the model
    for (int t = 0; t < 60; t++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Reset mid-WAIT aborts the op
    accept(1'b0, 3'b010, 32'h10, 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("abort_in_wait", 32'(s_ready), 32'd1);
    rstf = 1'b0;
    #1;
    chk_all_zero("abort");
    tick();
    tick();
    rstf = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("no_stray_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("post_abort_ready", 32'(req_ready), 32'd1);
    run_op(1'b0, 3'b101, 32'h12, 32'd0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
